// File: rtl/simd_warp_issuer_pkg.sv
// -----------------------------------------------------------------------------
// simd_warp_issuer_pkg
// Shared configuration for the warp-interleaved SIMD instruction issuer:
// default sizing constants and the issuer FSM state encoding.
// -----------------------------------------------------------------------------
package simd_warp_issuer_pkg;

    localparam int DEF_N_INST       = 16;  // instruction slots
    localparam int DEF_MAX_WARP     = 8;   // warps per block
    localparam int DEF_MAX_PENDING  = 8;   // global outstanding-instruction limit
    localparam int DEF_WARP_PENDING = 4;   // per-warp outstanding limit

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for a job
        ST_ISSUE = 2'd1,  // walking the PC x warp loop
        ST_DRAIN = 2'd2,  // last job issued, waiting for all commits
        ST_FIN   = 2'd3   // block complete, holding fin_rdy
    } issue_state_e;

endpackage

// File: rtl/simd_warp_credit.sv
// -----------------------------------------------------------------------------
// simd_warp_credit
// Outstanding-instruction bookkeeping: one saturating up/down counter per warp
// plus one global counter. An issue increments, a commit decrements; both on
// the same counter in one cycle leave it unchanged. A commit against an empty
// counter leaves it at zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inc, inc_wid      one instruction issued on warp inc_wid
//   dec, dec_wid      one instruction retired on warp dec_wid
//   g_full, g_empty   global counter at MAX_PENDING / at zero
//   w_full[w]         warp w counter at WARP_PENDING
// -----------------------------------------------------------------------------
module simd_warp_credit #(
    parameter int MAX_WARP     = 8,
    parameter int MAX_PENDING  = 8,
    parameter int WARP_PENDING = 4,
    parameter int WID_BW       = $clog2(MAX_WARP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic [WID_BW-1:0]   inc_wid,
    input  logic                dec,
    input  logic [WID_BW-1:0]   dec_wid,
    output logic                g_full,
    output logic                g_empty,
    output logic [MAX_WARP-1:0] w_full
);

    localparam int G_BW = $clog2(MAX_PENDING + 1);
    localparam int W_BW = $clog2(WARP_PENDING + 1);

    logic [G_BW-1:0]     gcnt, gcnt_nxt;
    logic [W_BW-1:0]     wcnt     [MAX_WARP];
    logic [W_BW-1:0]     wcnt_nxt [MAX_WARP];
    logic [MAX_WARP-1:0] w_inc, w_dec;

    always_comb begin
        // NOTE: every variable gets its default before any condition, so no path leaves one unassigned and no latch is inferred.
        gcnt_nxt = gcnt;
        if (inc && !dec)
            gcnt_nxt = gcnt + G_BW'(1);
        else if (dec && !inc && gcnt != '0)
            gcnt_nxt = gcnt - G_BW'(1);

        for (int w = 0; w < MAX_WARP; w++) begin
            w_inc[w]    = inc && (inc_wid == WID_BW'(w));
            w_dec[w]    = dec && (dec_wid == WID_BW'(w));
            wcnt_nxt[w] = wcnt[w];
            if (w_inc[w] && !w_dec[w])
                wcnt_nxt[w] = wcnt[w] + W_BW'(1);
            else if (w_dec[w] && !w_inc[w] && wcnt[w] != '0)
                wcnt_nxt[w] = wcnt[w] - W_BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt <= '0;
            // NOTE: this small array is live credit state, not a data RAM, so every entry is cleared on reset.
            for (int w = 0; w < MAX_WARP; w++)
                wcnt[w] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all counters update together from pre-edge values.
            gcnt <= gcnt_nxt;
            for (int w = 0; w < MAX_WARP; w++)
                wcnt[w] <= wcnt_nxt[w];
        end
    end

    assign g_full  = (gcnt == G_BW'(MAX_PENDING));
    assign g_empty = (gcnt == '0);

    always_comb begin
        for (int w = 0; w < MAX_WARP; w++)
            w_full[w] = (wcnt[w] == W_BW'(WARP_PENDING));
    end

`ifndef SYNTHESIS
    // A retire with nothing outstanding means upstream lost track of credits.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dec && !inc && gcnt == '0));
            assert (!(dec && !(inc && inc_wid == dec_wid) && wcnt[dec_wid] == '0));
        end
    end
`endif

endmodule

// File: rtl/simd_warp_issuer.sv
// -----------------------------------------------------------------------------
// simd_warp_issuer
// Accepts one job (PC range + active-warp count) per handshake and issues its
// instructions warp-interleaved (PC outer loop, warp inner loop) to the SIMD
// ALU, under a global and a per-warp outstanding limit. After the last job of
// a block it waits for every commit before raising fin_rdy.
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-low reset
//   job_rdy/job_ack                   job handshake (job_ack combinational)
//   i_pc_beg, i_pc_end                PC range [beg, end)
//   i_nwarp, i_islast, i_drain        warp count, last-job flag, drain-first mode
//   inst_rdy/inst_ack                 instruction handshake
//   o_pc, o_warpid, o_islast          issued instruction
//   inst_commit_dval, i_commit_warpid retire notification
//   fin_rdy/fin_ack                   block-complete handshake
//   o_busy                            activity or outstanding instructions
// -----------------------------------------------------------------------------
module simd_warp_issuer
    import simd_warp_issuer_pkg::*;
#(
    parameter int N_INST       = DEF_N_INST,
    parameter int MAX_WARP     = DEF_MAX_WARP,
    parameter int MAX_PENDING  = DEF_MAX_PENDING,
    parameter int WARP_PENDING = DEF_WARP_PENDING,
    parameter int INST_BW      = $clog2(N_INST + 1),
    parameter int WID_BW       = $clog2(MAX_WARP),
    parameter int NW_BW        = $clog2(MAX_WARP + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               job_rdy,
    output logic               job_ack,
    input  logic [INST_BW-1:0] i_pc_beg,
    input  logic [INST_BW-1:0] i_pc_end,
    input  logic [NW_BW-1:0]   i_nwarp,
    input  logic               i_islast,
    input  logic               i_drain,
    output logic               inst_rdy,
    input  logic               inst_ack,
    output logic [INST_BW-1:0] o_pc,
    output logic [WID_BW-1:0]  o_warpid,
    output logic               o_islast,
    input  logic               inst_commit_dval,
    input  logic [WID_BW-1:0]  i_commit_warpid,
    output logic               fin_rdy,
    input  logic               fin_ack,
    output logic               o_busy
);

    issue_state_e        state, state_nxt;
    logic [INST_BW-1:0]  pc, pc_last;
    logic [WID_BW-1:0]   wid, wid_last;
    logic                islast_r;
    logic                g_full, g_empty;
    logic [MAX_WARP-1:0] w_full;
    logic                job_empty, at_last, fire;

    assign job_empty = (i_pc_beg >= i_pc_end) || (i_nwarp == '0);
    assign at_last   = (pc == pc_last) && (wid == wid_last);
    assign fire      = inst_rdy && inst_ack;

    simd_warp_credit #(
        .MAX_WARP     (MAX_WARP),
        .MAX_PENDING  (MAX_PENDING),
        .WARP_PENDING (WARP_PENDING),
        .WID_BW       (WID_BW)
    ) u_credit (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .inc     (fire),
        .inc_wid (wid),
        .dec     (inst_commit_dval),
        .dec_wid (i_commit_warpid),
        .g_full  (g_full),
        .g_empty (g_empty),
        .w_full  (w_full)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (job_ack)
                          state_nxt = job_empty ? (i_islast ? ST_DRAIN : ST_IDLE) : ST_ISSUE;
            ST_ISSUE: if (fire && at_last)
                          state_nxt = islast_r ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (g_empty) state_nxt = ST_FIN;
            ST_FIN:   if (fin_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        job_ack  = 1'b0;
        inst_rdy = 1'b0;
        fin_rdy  = 1'b0;
        case (state)
            // Drain mode holds the job until every earlier instruction retired.
            ST_IDLE:  job_ack  = job_rdy && !(i_drain && !g_empty);
            ST_ISSUE: inst_rdy = !(g_full || w_full[wid]);
            ST_FIN:   fin_rdy  = 1'b1;
            default:  ;
        endcase
    end

    // Loop registers. The final (pc, wid) pair is held rather than advanced so
    // pc never runs past pc_end-1.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc       <= '0;
            pc_last  <= '0;
            wid      <= '0;
            wid_last <= '0;
            islast_r <= 1'b0;
        end else if (job_ack) begin
            islast_r <= i_islast;
            if (!job_empty) begin
                pc       <= i_pc_beg;
                pc_last  <= i_pc_end - INST_BW'(1);
                wid      <= '0;
                wid_last <= WID_BW'(i_nwarp - NW_BW'(1));
            end
        end else if (fire && !at_last) begin
            if (wid == wid_last) begin
                wid <= '0;
                pc  <= pc + INST_BW'(1);
            end else begin
                wid <= wid + WID_BW'(1);
            end
        end
    end

    assign o_pc     = pc;
    assign o_warpid = wid;
    assign o_islast = (state == ST_ISSUE) && islast_r && at_last;
    assign o_busy   = (state != ST_IDLE) || !g_empty;

endmodule
